// File: rtl/sysbus_mem_responder.sv
// Sysbus memory slave: serves 8-beat bursts that wrap within a 64-byte line.
// Optional macro MEMRESP_TAGCHECK_EN rejects requests whose device field is not `SYSBUS_MEMORY.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int RESP_LATENCY   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);
   localparam int IDX_W = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {IDLE, ACK, LAT, RDATA, WDATA} state_t;

   state_t                    state_reg, state_next;
   // Only the word-address bits that reach the storage are kept; byte offset and
   // bits above the storage depth never influence indexing.
   logic [IDX_W-1:0]          addr_reg, addr_next;
   logic [BUS_TAG_WIDTH-1:0]  tag_reg, tag_next;
   logic [2:0]                beat_reg, beat_next;
   logic [3:0]                lat_reg, lat_next;
   logic [2:0]                rd_beat;
   logic                      mem_we;
   logic                      reqack_int;
   logic                      respcyc_int;
   logic                      tag_ok;
   logic [IDX_W-1:0]          rd_idx;
   logic [IDX_W-1:0]          wr_idx;
   logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [BUS_DATA_WIDTH-1:0] rdata_reg;

   function automatic logic [IDX_W-1:0] beat_index(input logic [IDX_W-1:0] base,
                                                   input logic [2:0] beat);
      return {base[IDX_W-1:3], base[2:0] + beat};
   endfunction

`ifdef MEMRESP_TAGCHECK_EN
   assign tag_ok = (bus_reqtag[11:8] == `SYSBUS_MEMORY);
`else
   assign tag_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         tag_reg   <= '0;
         beat_reg  <= '0;
         lat_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         tag_reg   <= tag_next;
         beat_reg  <= beat_next;
         lat_reg   <= lat_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      tag_next    = tag_reg;
      beat_next   = beat_reg;
      lat_next    = lat_reg;
      rd_beat     = beat_reg;
      reqack_int  = 1'b0;
      respcyc_int = 1'b0;
      mem_we      = 1'b0;
      case (state_reg)
         IDLE: begin
            beat_next = '0;
            lat_next  = '0;
            if (bus_reqcyc && tag_ok) begin
               addr_next  = bus_req[IDX_W+2:3];
               tag_next   = bus_reqtag;
               state_next = ACK;
            end
         end
         ACK: begin
            reqack_int = 1'b1;
            if (tag_reg[BUS_TAG_WIDTH-1])
               state_next = (RESP_LATENCY == 0) ? RDATA : LAT;
            else
               state_next = WDATA;
         end
         LAT: begin
            if (lat_reg == 4'(RESP_LATENCY - 1)) begin
               lat_next   = '0;
               state_next = RDATA;
            end else begin
               lat_next = lat_reg + 4'd1;
            end
         end
         RDATA: begin
            respcyc_int = 1'b1;
            // Prefetch the next beat on acceptance so the registered read keeps up.
            if (bus_respack) begin
               rd_beat   = beat_reg + 3'd1;
               beat_next = beat_reg + 3'd1;
               if (beat_reg == 3'd7)
                  state_next = IDLE;
            end
         end
         WDATA: begin
            if (bus_reqcyc) begin
               reqack_int = 1'b1;
               mem_we     = reset;
               beat_next  = beat_reg + 3'd1;
               if (beat_reg == 3'd7)
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rd_idx = beat_index(addr_reg, rd_beat);
   assign wr_idx = beat_index(addr_reg, beat_reg);

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_idx] <= bus_req;
      rdata_reg <= mem[rd_idx];
   end

   // Outputs are forced quiet while reset is held, independent of the state register.
   assign bus_reqack  = reqack_int & reset;
   assign bus_respcyc = respcyc_int & reset;
   assign bus_resp    = bus_respcyc ? rdata_reg : '0;
   assign bus_resptag = bus_respcyc ? tag_reg : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed bursts plus randomized
// write/read traffic checked against a line-wrapping memory model.
module tb_sysbus_mem_responder;
   localparam int MEM_WORDS    = 4096;
   localparam int RESP_LATENCY = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        bus_reqcyc = 1'b0;
   logic [63:0] bus_req = '0;
   logic [12:0] bus_reqtag = '0;
   logic        bus_respack = 1'b0;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;

   sysbus_mem_responder #(
      .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13),
      .MEM_WORDS(MEM_WORDS), .RESP_LATENCY(RESP_LATENCY)
   ) dut (
      .clk(clk), .reset(reset),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
      .bus_resptag(bus_resptag), .bus_respack(bus_respack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [63:0] model_mem [int];
   logic [63:0] obs_data [8];
   logic [12:0] obs_tag [8];
   logic [63:0] w_data [8];
   int ack_cyc, first_cyc, beats, extra_ack, bad_ack, beat_acks;
   bit hold_ok, timed_out;

   // Word touched by beat i: same 64-byte line, word offset advances mod 8.
   function automatic int word_of(input logic [63:0] a, input int i);
      logic [63:0] w;
      w = a >> 3;
      return int'(((w & ~64'h7) + ((w + 64'(i)) & 64'h7)) % 64'(MEM_WORDS));
   endfunction

   task automatic do_write(input logic [63:0] a, input logic [12:0] t, input bit stalls);
      int cyc = 0;
      bit data_phase = 0;
      ack_cyc = -1; beat_acks = 0; bad_ack = 0; timed_out = 0;
      bus_reqcyc = 1'b1; bus_req = a; bus_reqtag = t;
      while (beat_acks < 8) begin
         if (cyc >= 200) begin timed_out = 1; break; end
         @(negedge clk);
         if (!data_phase) begin
            if (bus_reqack) begin ack_cyc = cyc; data_phase = 1; end
         end else begin
            if (bus_reqack !== bus_reqcyc) bad_ack++;
            if (bus_reqcyc && bus_reqack) beat_acks++;
         end
         @(posedge clk); #1; cyc++;
         if (data_phase && beat_acks < 8) begin
            bus_reqcyc = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus_req    = w_data[beat_acks];
         end else if (data_phase) begin
            bus_reqcyc = 1'b0;
         end
      end
      bus_reqcyc = 1'b0;
      $display("write addr=%h tag=%h ack_cyc=%0d beats=%0d cycles=%0d", a, t, ack_cyc, beat_acks, cyc);
   endtask

   task automatic do_read(input logic [63:0] a, input logic [12:0] t, input int mode,
                          input bit hold, input logic [63:0] next_a, input logic [12:0] next_t,
                          input int abort_n);
      int cyc = 0;
      bit have_prev = 0;
      logic [63:0] prev_d;
      logic [12:0] prev_t;
      prev_d = '0; prev_t = '0;
      ack_cyc = -1; first_cyc = -1; beats = 0; extra_ack = 0; hold_ok = 1; timed_out = 0;
      for (int i = 0; i < 8; i++) begin obs_data[i] = '0; obs_tag[i] = '0; end
      bus_reqcyc = 1'b1; bus_req = a; bus_reqtag = t;
      while (beats < abort_n) begin
         if (cyc >= 200) begin timed_out = 1; break; end
         case (mode)
            0:       bus_respack = 1'b1;
            1:       bus_respack = (cyc % 2 == 0);
            default: bus_respack = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (bus_reqack) begin
            if (ack_cyc < 0) ack_cyc = cyc;
            else extra_ack++;
         end
         if (bus_respcyc) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (have_prev && (bus_resp !== prev_d || bus_resptag !== prev_t)) hold_ok = 0;
            if (bus_respack) begin
               obs_data[beats] = bus_resp; obs_tag[beats] = bus_resptag;
               beats++; have_prev = 0;
            end else begin
               have_prev = 1; prev_d = bus_resp; prev_t = bus_resptag;
            end
         end
         @(posedge clk); #1; cyc++;
         if (ack_cyc >= 0) begin
            if (hold) begin bus_req = next_a; bus_reqtag = next_t; end
            else bus_reqcyc = 1'b0;
         end
      end
      bus_respack = 1'b0;
      if (!hold) bus_reqcyc = 1'b0;
      $display("read addr=%h tag=%h ack_cyc=%0d first_beat_cyc=%0d beats=%0d", a, t, ack_cyc, first_cyc, beats);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus_reqack !== 1'b0) begin n_fail++; $display("FAIL reset_reqack got %b expected 0", bus_reqack); end
      n_cmp++; if (bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL reset_respcyc got %b expected 0", bus_respcyc); end
      n_cmp++; if (bus_resp !== 64'h0) begin n_fail++; $display("FAIL reset_resp got %h expected 0", bus_resp); end
      n_cmp++; if (bus_resptag !== 13'h0) begin n_fail++; $display("FAIL reset_resptag got %h expected 0", bus_resptag); end
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus_reqack, bus_respcyc, bus_resp, bus_resptag} !== 79'h0) begin
         n_fail++; $display("FAIL post_reset_outputs got %h expected 0", {bus_reqack, bus_respcyc, bus_resp, bus_resptag}); end
      @(posedge clk); #1;
      $display("reset sequence done");
   endtask

   task automatic test_write_burst;
      for (int i = 0; i < 8; i++) w_data[i] = 64'hA0 + 64'(i);
      do_write(64'h1000, 13'h0100, 0);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL wr_timeout got timeout expected completion"); end
      n_cmp++; if (ack_cyc != 1) begin n_fail++; $display("FAIL wr_ack_cyc got %0d expected 1", ack_cyc); end
      n_cmp++; if (beat_acks != 8) begin n_fail++; $display("FAIL wr_beat_acks got %0d expected 8", beat_acks); end
      n_cmp++; if (bad_ack != 0) begin n_fail++; $display("FAIL wr_ack_follows_reqcyc got %0d bad cycles expected 0", bad_ack); end
      for (int i = 0; i < 8; i++) model_mem[word_of(64'h1000, i)] = w_data[i];
   endtask

   task automatic test_read_burst;
      do_read(64'h1000, 13'h1100, 0, 0, '0, '0, 8);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rd_timeout got timeout expected completion"); end
      n_cmp++; if (ack_cyc != 1) begin n_fail++; $display("FAIL rd_ack_cyc got %0d expected 1", ack_cyc); end
      n_cmp++; if (first_cyc - ack_cyc != RESP_LATENCY + 1) begin
         n_fail++; $display("FAIL rd_first_beat_delay got %0d expected %0d", first_cyc - ack_cyc, RESP_LATENCY + 1); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (obs_data[i] !== 64'hA0 + 64'(i)) begin
            n_fail++; $display("FAIL rd_data[%0d] got %h expected %h", i, obs_data[i], 64'hA0 + 64'(i)); end
         n_cmp++; if (obs_tag[i] !== 13'h1100) begin
            n_fail++; $display("FAIL rd_tag[%0d] got %h expected 1100", i, obs_tag[i]); end
      end
      @(negedge clk);
      n_cmp++; if (bus_respcyc !== 1'b0 || bus_resp !== 64'h0) begin
         n_fail++; $display("FAIL rd_idle_after got respcyc=%b resp=%h expected 0/0", bus_respcyc, bus_resp); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap_backpressure;
      do_read(64'h1028, 13'h1100, 1, 0, '0, '0, 8);
      n_cmp++; if (timed_out) begin n_fail++; $display("FAIL wrap_timeout got timeout expected completion"); end
      n_cmp++; if (!hold_ok) begin n_fail++; $display("FAIL wrap_stable got unstable data expected stable under backpressure"); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (obs_data[i] !== 64'hA0 + 64'((5 + i) % 8)) begin
            n_fail++; $display("FAIL wrap_data[%0d] got %h expected %h", i, obs_data[i], 64'hA0 + 64'((5 + i) % 8)); end
      end
   endtask

   task automatic test_reset_mid_burst;
      do_read(64'h1000, 13'h1100, 0, 0, '0, '0, 3);
      n_cmp++; if (beats != 3 || obs_data[2] !== 64'hA2) begin
         n_fail++; $display("FAIL mid_pre_beats got %0d/%h expected 3/a2", beats, obs_data[2]); end
      reset = 1'b0; bus_respack = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL mid_reset_respcyc got %b expected 0", bus_respcyc); end
      @(posedge clk); #1; reset = 1'b1; bus_respack = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus_reqack, bus_respcyc, bus_resp, bus_resptag} !== 79'h0) begin
         n_fail++; $display("FAIL mid_after_reset got %h expected 0", {bus_reqack, bus_respcyc, bus_resp, bus_resptag}); end
      @(posedge clk); #1;
      do_read(64'h1000, 13'h1100, 0, 0, '0, '0, 8);
      n_cmp++; if (ack_cyc != 1) begin n_fail++; $display("FAIL mid_reread_ack got %0d expected 1", ack_cyc); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (obs_data[i] !== model_mem[word_of(64'h1000, i)]) begin
            n_fail++; $display("FAIL mid_reread[%0d] got %h expected %h", i, obs_data[i], model_mem[word_of(64'h1000, i)]); end
      end
   endtask

   task automatic test_tagcheck;
`ifdef MEMRESP_TAGCHECK_EN
      int acks = 0;
      int resps = 0;
      bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1F00;
      repeat (20) begin
         @(negedge clk);
         if (bus_reqack) acks++;
         if (bus_respcyc) resps++;
         @(posedge clk); #1;
      end
      bus_reqcyc = 1'b0;
      $display("tagcheck request tag=1f00 held 20 cycles acks=%0d", acks);
      n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL tag_reject_ack got %0d expected 0", acks); end
      n_cmp++; if (resps != 0) begin n_fail++; $display("FAIL tag_reject_resp got %0d expected 0", resps); end
      do_read(64'h1000, 13'h1100, 0, 0, '0, '0, 8);
      n_cmp++; if (ack_cyc != 1 || obs_data[0] !== 64'hA0) begin
         n_fail++; $display("FAIL tag_followup got ack=%0d d0=%h expected 1/a0", ack_cyc, obs_data[0]); end
`else
      do_read(64'h1000, 13'h1F00, 0, 0, '0, '0, 8);
      n_cmp++; if (ack_cyc != 1) begin n_fail++; $display("FAIL tag_accept_ack got %0d expected 1", ack_cyc); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (obs_data[i] !== 64'hA0 + 64'(i) || obs_tag[i] !== 13'h1F00) begin
            n_fail++; $display("FAIL tag_accept[%0d] got %h/%h expected %h/1f00", i, obs_data[i], obs_tag[i], 64'hA0 + 64'(i)); end
      end
`endif
   endtask

   task automatic test_back_to_back;
      do_read(64'h1000, 13'h1100, 0, 1, 64'h1028, 13'h1155, 8);
      n_cmp++; if (extra_ack != 0) begin n_fail++; $display("FAIL b2b_no_ack_during_burst got %0d expected 0", extra_ack); end
      n_cmp++; if (obs_tag[7] !== 13'h1100 || obs_data[7] !== 64'hA7) begin
         n_fail++; $display("FAIL b2b_first_burst got %h/%h expected 1100/a7", obs_tag[7], obs_data[7]); end
      do_read(64'h1028, 13'h1155, 2, 0, '0, '0, 8);
      n_cmp++; if (ack_cyc != 1) begin n_fail++; $display("FAIL b2b_second_ack got %0d expected 1", ack_cyc); end
      n_cmp++; if (first_cyc - ack_cyc != RESP_LATENCY + 1) begin
         n_fail++; $display("FAIL b2b_second_delay got %0d expected %0d", first_cyc - ack_cyc, RESP_LATENCY + 1); end
      n_cmp++; if (!hold_ok) begin n_fail++; $display("FAIL b2b_stable got unstable expected stable"); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (obs_data[i] !== 64'hA0 + 64'((5 + i) % 8) || obs_tag[i] !== 13'h1155) begin
            n_fail++; $display("FAIL b2b_data[%0d] got %h/%h expected %h/1155", i, obs_data[i], obs_tag[i], 64'hA0 + 64'((5 + i) % 8)); end
      end
   endtask

   task automatic test_random;
      logic [63:0] wa, ra;
      logic [12:0] wt, rt;
      for (int it = 0; it < 8; it++) begin
         wa = {$urandom, $urandom};
         for (int i = 0; i < 8; i++) w_data[i] = {$urandom, $urandom};
         wt = {1'b0, 4'h1, 8'($urandom)};
         do_write(wa, wt, 1);
         n_cmp++; if (timed_out || beat_acks != 8 || bad_ack != 0) begin
            n_fail++; $display("FAIL rnd_write[%0d] got timeout=%0d acks=%0d bad=%0d expected 0/8/0", it, timed_out, beat_acks, bad_ack); end
         for (int i = 0; i < 8; i++) model_mem[word_of(wa, i)] = w_data[i];
         ra = {wa[63:6], 3'($urandom), 3'($urandom)};
         rt = {1'b1, 4'h1, 8'($urandom)};
         do_read(ra, rt, 2, 0, '0, '0, 8);
         n_cmp++; if (timed_out || !hold_ok) begin
            n_fail++; $display("FAIL rnd_read[%0d] got timeout=%0d stable=%0d expected 0/1", it, timed_out, hold_ok); end
         for (int i = 0; i < 8; i++) begin
            n_cmp++; if (obs_data[i] !== model_mem[word_of(ra, i)] || obs_tag[i] !== rt) begin
               n_fail++; $display("FAIL rnd_data[%0d][%0d] got %h/%h expected %h/%h", it, i, obs_data[i], obs_tag[i], model_mem[word_of(ra, i)], rt); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_write_burst;
      test_read_burst;
      test_wrap_backpressure;
      test_reset_mid_burst;
      test_tagcheck;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no completion expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
